// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SERVE_INSTR = 2'd1,
    SERVE_DATA  = 2'd2
  } MemArbState_t;

  localparam logic GRANT_INSTR = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin 2:1 arbiter between instruction-fetch and data ports onto a
// single shared memory port; responder for both initiator ports.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [19:1] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel
);

  MemArbState_t state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         instr_hold_q, instr_hold_d;
  logic         data_hold_q, data_hold_d;
  logic         instr_req, data_req;

  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

  // A port's access is masked for the one IDLE cycle after its own ack, so a
  // request still high while the initiator retires cannot be granted again.
  assign instr_req = instr_m_access & ~instr_hold_q;
  assign data_req  = data_m_access & ~data_hold_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    q_m_access   = 1'b0;
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = '0;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (instr_req && data_req) begin
          if (last_grant_q == GRANT_INSTR) begin
            state_d      = SERVE_DATA;
            last_grant_d = GRANT_DATA;
          end else begin
            state_d      = SERVE_INSTR;
            last_grant_d = GRANT_INSTR;
          end
        end else if (instr_req) begin
          state_d      = SERVE_INSTR;
          last_grant_d = GRANT_INSTR;
        end else if (data_req) begin
          state_d      = SERVE_DATA;
          last_grant_d = GRANT_DATA;
        end
      end
      SERVE_INSTR: begin
        q_m_access  = 1'b1;
        q_m_addr    = instr_m_addr;
        q_m_bytesel = 2'b11;
        // Acks are suppressed while reset is asserted so an abandoned
        // transfer never completes towards the initiator.
        instr_m_ack = q_m_ack & ~reset;
        if (q_m_ack) state_d = IDLE;
      end
      SERVE_DATA: begin
        q_m_access   = 1'b1;
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        data_m_ack   = q_m_ack & ~reset;
        if (q_m_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    instr_hold_d = instr_m_ack;
    data_hold_d  = data_m_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_INSTR;
      instr_hold_q <= 1'b0;
      data_hold_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      instr_hold_q <= instr_hold_d;
      data_hold_q  <= data_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-by-cycle vectors plus a contention sequence for mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] instr_m_addr;
  logic [15:0] instr_m_data_in;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_ack;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_in;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;

  mem_arbiter u_dut (
    .clk             (clk),
    .reset           (reset),
    .instr_m_addr    (instr_m_addr),
    .instr_m_data_in (instr_m_data_in),
    .instr_m_access  (instr_m_access),
    .instr_m_ack     (instr_m_ack),
    .data_m_addr     (data_m_addr),
    .data_m_data_in  (data_m_data_in),
    .data_m_data_out (data_m_data_out),
    .data_m_access   (data_m_access),
    .data_m_ack      (data_m_ack),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_bytesel  (data_m_bytesel),
    .q_m_addr        (q_m_addr),
    .q_m_data_in     (q_m_data_in),
    .q_m_data_out    (q_m_data_out),
    .q_m_access      (q_m_access),
    .q_m_ack         (q_m_ack),
    .q_m_wr_en       (q_m_wr_en),
    .q_m_bytesel     (q_m_bytesel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ia;
    logic [18:0] iaddr;
    logic        da;
    logic [18:0] daddr;
    logic [15:0] ddo;
    logic        dwe;
    logic [1:0]  dbs;
    logic        qack;
    logic [15:0] qdin;
    logic        e_acc;
    logic [18:0] e_addr;
    logic        e_we;
    logic [1:0]  e_bs;
    logic [15:0] e_do;
    logic        e_iack;
    logic        e_dack;
  } vec_t;

  localparam int unsigned NVEC = 21;
  vec_t vecs [NVEC];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [89:0] act_v, exp_v;

  initial begin
    // rst ia iaddr    da daddr    ddo      we bs     qack qdin     | acc addr     we bs     do       iack dack
    vecs[0]  = '{1'b1,1'b0,19'h00000,1'b0,19'h00000,16'h0000,1'b0,2'b00,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    // single data write, memory acks on the second SERVE cycle
    vecs[1]  = '{1'b0,1'b0,19'h00000,1'b1,19'h00100,16'hBEEF,1'b1,2'b01,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,19'h00000,1'b1,19'h00100,16'hBEEF,1'b1,2'b01,1'b0,16'h0000, 1'b1,19'h00100,1'b1,2'b01,16'hBEEF,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,19'h00000,1'b1,19'h00100,16'hBEEF,1'b1,2'b01,1'b1,16'h1234, 1'b1,19'h00100,1'b1,2'b01,16'hBEEF,1'b0,1'b1};
    vecs[4]  = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,16'h0000,1'b0,2'b00,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    // tie with last grant DATA: instruction read wins, read-only forcing
    vecs[5]  = '{1'b0,1'b1,19'h7FFF8,1'b1,19'h12345,16'hFFFF,1'b1,2'b01,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,19'h7FFF8,1'b1,19'h12345,16'hFFFF,1'b1,2'b01,1'b1,16'h90EB, 1'b1,19'h7FFF8,1'b0,2'b11,16'h0000,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,16'h0000,1'b0,2'b00,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    // spurious ack while idle
    vecs[8]  = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,16'h0000,1'b0,2'b00,1'b1,16'hDEAD, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,16'h0000,1'b0,2'b00,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    // zero-wait data read, then stale data access must not re-grant
    vecs[10] = '{1'b0,1'b0,19'h00000,1'b1,19'h00200,16'h0055,1'b0,2'b10,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,19'h00000,1'b1,19'h00200,16'h0055,1'b0,2'b10,1'b1,16'hAAAA, 1'b1,19'h00200,1'b0,2'b10,16'h0055,1'b0,1'b1};
    vecs[12] = '{1'b0,1'b0,19'h00000,1'b1,19'h00200,16'h0055,1'b0,2'b10,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b1,19'h00010,1'b0,19'h00000,16'h0000,1'b0,2'b00,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    vecs[14] = '{1'b0,1'b1,19'h00010,1'b0,19'h00000,16'h0000,1'b0,2'b00,1'b0,16'h0000, 1'b1,19'h00010,1'b0,2'b11,16'h0000,1'b0,1'b0};
    vecs[15] = '{1'b0,1'b1,19'h00010,1'b0,19'h00000,16'h0000,1'b0,2'b00,1'b1,16'h5A5A, 1'b1,19'h00010,1'b0,2'b11,16'h0000,1'b1,1'b0};
    vecs[16] = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,16'h0000,1'b0,2'b00,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    // tie with last grant INSTR: data wins; then reset with ack on 2nd SERVE cycle
    vecs[17] = '{1'b0,1'b1,19'h00020,1'b1,19'h0ABCD,16'h1357,1'b1,2'b11,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
    vecs[18] = '{1'b0,1'b1,19'h00020,1'b1,19'h0ABCD,16'h1357,1'b1,2'b11,1'b0,16'h0000, 1'b1,19'h0ABCD,1'b1,2'b11,16'h1357,1'b0,1'b0};
    vecs[19] = '{1'b1,1'b1,19'h00020,1'b1,19'h0ABCD,16'h1357,1'b1,2'b11,1'b1,16'h7777, 1'b1,19'h0ABCD,1'b1,2'b11,16'h1357,1'b0,1'b0};
    vecs[20] = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,16'h0000,1'b0,2'b00,1'b0,16'h0000, 1'b0,19'h00000,1'b0,2'b00,16'h0000,1'b0,1'b0};
  end

  task automatic drive(input vec_t v);
    reset           = v.rst;
    instr_m_access  = v.ia;
    instr_m_addr    = v.iaddr;
    data_m_access   = v.da;
    data_m_addr     = v.daddr;
    data_m_data_out = v.ddo;
    data_m_wr_en    = v.dwe;
    data_m_bytesel  = v.dbs;
    q_m_ack         = v.qack;
    q_m_data_in     = v.qdin;
  endtask

  // Contention sequence state
  logic [5:0]  exp_grant_data = 6'b010101; // bit k: grant k is DATA
  int unsigned n_grant;
  int unsigned idle_run;
  logic        got_data;

  initial begin
    drive('0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      act_v = {q_m_access, q_m_addr, q_m_wr_en, q_m_bytesel, q_m_data_out,
               instr_m_ack, data_m_ack, instr_m_data_in, data_m_data_in};
      exp_v = {vecs[i].e_acc, vecs[i].e_addr, vecs[i].e_we, vecs[i].e_bs, vecs[i].e_do,
               vecs[i].e_iack, vecs[i].e_dack, vecs[i].qdin, vecs[i].qdin};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL vec%0d: got acc=%b addr=%h we=%b bs=%b do=%h iack=%b dack=%b idin=%h ddin=%h, want acc=%b addr=%h we=%b bs=%b do=%h iack=%b dack=%b din=%h",
                 i, q_m_access, q_m_addr, q_m_wr_en, q_m_bytesel, q_m_data_out,
                 instr_m_ack, data_m_ack, instr_m_data_in, data_m_data_in,
                 vecs[i].e_acc, vecs[i].e_addr, vecs[i].e_we, vecs[i].e_bs, vecs[i].e_do,
                 vecs[i].e_iack, vecs[i].e_dack, vecs[i].qdin);
      end
      @(posedge clk);
      #1;
    end

    // Contention: both ports request continuously, zero-wait memory.
    drive('0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset          = 1'b0;
    instr_m_access = 1'b1;
    instr_m_addr   = 19'h00400;
    data_m_access  = 1'b1;
    data_m_addr    = 19'h00800;
    q_m_ack        = 1'b1;
    n_grant  = 0;
    idle_run = 0;
    for (int c = 0; c < 40 && n_grant < 6; c++) begin
      @(negedge clk);
      if (!q_m_access) begin
        idle_run++;
      end else if (instr_m_ack || data_m_ack) begin
        got_data = data_m_ack;
        n_cmp++;
        if ((instr_m_ack && data_m_ack) || got_data !== exp_grant_data[n_grant]) begin
          n_fail++;
          $display("FAIL grant%0d: got iack=%b dack=%b, want %s", n_grant,
                   instr_m_ack, data_m_ack, exp_grant_data[n_grant] ? "DATA" : "INSTR");
        end
        if (n_grant > 0) begin
          n_cmp++;
          if (idle_run != 1) begin
            n_fail++;
            $display("FAIL gap%0d: got %0d idle cycles, want 1", n_grant, idle_run);
          end
        end
        idle_run = 0;
        n_grant++;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (n_grant != 6) begin
      n_fail++;
      $display("FAIL contention_timeout: got %0d grants, want 6", n_grant);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
